// File: rtl/ffm_pkg.sv
// Shared types and helpers for the frame-former input queue.
// Holds the word type, the zero pad word and the tkeep byte-masking function.
package ffm_pkg;

  localparam int FFM_DATA_WIDTH = 64;
  localparam int FFM_KEEP_WIDTH = 8;

  typedef logic [FFM_DATA_WIDTH-1:0] ffm_word_t;

  localparam ffm_word_t FFM_ZERO_WORD = '0;

  // Bytes whose keep bit is clear are stored as 0x00.
  function automatic ffm_word_t keep_mask(input ffm_word_t tdata,
                                          input logic [FFM_KEEP_WIDTH-1:0] tkeep);
    ffm_word_t masked;
    masked = FFM_ZERO_WORD;
    for (int i = 0; i < FFM_KEEP_WIDTH; i++) begin
      if (tkeep[i]) masked[i*8 +: 8] = tdata[i*8 +: 8];
    end
    return masked;
  endfunction

endpackage

// File: rtl/ffm_queue_ram.sv
// Storage array for the input queue: synchronous write, asynchronous read.
// No control logic; the parent owns pointers and flags.
module ffm_queue_ram
  import ffm_pkg::*;
#(
  parameter int DEPTH      = 512,
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  ffm_word_t             wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output ffm_word_t             rdata
);

  ffm_word_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ffm_input_queue.sv
// Show-ahead word queue feeding the frame former; the head word reads as zero
// when empty so short payloads are zero-padded, and empty pops are counted.
module ffm_input_queue
  import ffm_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 512,
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [DATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic [7:0]            S_AXIS_tkeep,
  input  logic                  S_AXIS_tvalid,
  output logic                  S_AXIS_tready,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] Output_Data,
  output logic                  is_empty,
  output logic                  is_full,
  output logic [DEPTH_LOG2:0]   occupancy,
  output logic [15:0]           underflow_count
);

  localparam int PTR_W = DEPTH_LOG2 + 1;

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W-1:0] wr_ptr_nxt, rd_ptr_nxt;
  logic             tready_q;
  logic             push, rd_en, underflow, full_nxt;
  ffm_word_t        head_word, wr_word;

  assign push      = S_AXIS_tvalid && tready_q;
  assign rd_en     = pop && !is_empty;
  assign underflow = pop && is_empty;

  assign wr_ptr_nxt = wr_ptr + {{DEPTH_LOG2{1'b0}}, push};
  assign rd_ptr_nxt = rd_ptr + {{DEPTH_LOG2{1'b0}}, rd_en};

  // tready is registered from the post-edge full state so it tracks occupancy exactly.
  assign full_nxt = (wr_ptr_nxt[DEPTH_LOG2-1:0] == rd_ptr_nxt[DEPTH_LOG2-1:0]) &&
                    (wr_ptr_nxt[DEPTH_LOG2] != rd_ptr_nxt[DEPTH_LOG2]);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      tready_q        <= 1'b0;
      underflow_count <= '0;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      tready_q <= !full_nxt;
      if (underflow && (underflow_count != 16'hFFFF))
        underflow_count <= underflow_count + 16'd1;
    end
  end

  assign is_empty  = (wr_ptr == rd_ptr);
  assign is_full   = (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]) &&
                     (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]);
  assign occupancy = wr_ptr - rd_ptr;

  assign S_AXIS_tready = tready_q;
  assign wr_word       = keep_mask(S_AXIS_tdata, S_AXIS_tkeep);

  ffm_queue_ram #(
    .DEPTH      (DEPTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk   (ACLK),
    .we    (push),
    .waddr (wr_ptr[DEPTH_LOG2-1:0]),
    .wdata (wr_word),
    .raddr (rd_ptr[DEPTH_LOG2-1:0]),
    .rdata (head_word)
  );

  assign Output_Data = is_empty ? FFM_ZERO_WORD : head_word;

endmodule

// File: tb/tb_ffm_input_queue.sv
// Directed bench for ffm_input_queue: a DEPTH=4 instance for corner cases and
// a DEPTH=512 instance for sustained streaming across pointer wrap and mid-stream reset.
module tb_ffm_input_queue;

  logic        clk = 1'b0;
  logic        rst_n;

  logic [63:0] s_tdata;
  logic [7:0]  s_tkeep;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_pop;
  logic [63:0] s_out;
  logic        s_empty, s_full;
  logic [2:0]  s_occ;
  logic [15:0] s_ufl;

  logic        b_rst_n;
  logic [63:0] b_tdata;
  logic        b_tvalid;
  logic        b_tready;
  logic        b_pop;
  logic [63:0] b_out;
  logic        b_empty, b_full;
  logic [9:0]  b_occ;
  logic [15:0] b_ufl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ffm_input_queue #(.DATA_WIDTH(64), .DEPTH(4), .DEPTH_LOG2(2)) dut_small (
    .ACLK            (clk),
    .ARESETN         (rst_n),
    .S_AXIS_tdata    (s_tdata),
    .S_AXIS_tkeep    (s_tkeep),
    .S_AXIS_tvalid   (s_tvalid),
    .S_AXIS_tready   (s_tready),
    .pop             (s_pop),
    .Output_Data     (s_out),
    .is_empty        (s_empty),
    .is_full         (s_full),
    .occupancy       (s_occ),
    .underflow_count (s_ufl)
  );

  ffm_input_queue #(.DATA_WIDTH(64), .DEPTH(512), .DEPTH_LOG2(9)) dut_big (
    .ACLK            (clk),
    .ARESETN         (b_rst_n),
    .S_AXIS_tdata    (b_tdata),
    .S_AXIS_tkeep    (8'hFF),
    .S_AXIS_tvalid   (b_tvalid),
    .S_AXIS_tready   (b_tready),
    .pop             (b_pop),
    .Output_Data     (b_out),
    .is_empty        (b_empty),
    .is_full         (b_full),
    .occupancy       (b_occ),
    .underflow_count (b_ufl)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          mism;
    logic [63:0] exp_rd;

    rst_n = 1'b0; b_rst_n = 1'b0;
    s_tdata = '0; s_tkeep = 8'hFF; s_tvalid = 1'b0; s_pop = 1'b0;
    b_tdata = '0; b_tvalid = 1'b0; b_pop = 1'b0;

    repeat (3) step();
    chk("rst_empty", {63'd0, s_empty}, 64'd1);
    chk("rst_full", {63'd0, s_full}, 64'd0);
    chk("rst_tready", {63'd0, s_tready}, 64'd0);
    chk("rst_data", s_out, 64'd0);
    chk("rst_occ", {61'd0, s_occ}, 64'd0);

    rst_n = 1'b1; b_rst_n = 1'b1;
    #1;
    chk("release_tready_low", {63'd0, s_tready}, 64'd0);
    step();
    chk("release_tready_high", {63'd0, s_tready}, 64'd1);
    chk("idle_empty", {63'd0, s_empty}, 64'd1);
    chk("idle_data", s_out, 64'd0);

    // Three pushes, then drain.
    s_tvalid = 1'b1; s_tdata = 64'h1111;
    step();
    chk("push1_head", s_out, 64'h1111);
    chk("push1_occ", {61'd0, s_occ}, 64'd1);
    s_tdata = 64'h2222; step();
    s_tdata = 64'h3333; step();
    s_tvalid = 1'b0;
    chk("push3_occ", {61'd0, s_occ}, 64'd3);
    chk("push3_head", s_out, 64'h1111);
    s_pop = 1'b1;
    step(); chk("pop1_head", s_out, 64'h2222);
    step(); chk("pop2_head", s_out, 64'h3333);
    step(); chk("pop3_head", s_out, 64'd0);
    s_pop = 1'b0;
    chk("drain_empty", {63'd0, s_empty}, 64'd1);

    // Byte masking by tkeep.
    s_tvalid = 1'b1; s_tdata = 64'hAABBCCDDEEFF0011; s_tkeep = 8'h0F;
    step();
    s_tvalid = 1'b0; s_tkeep = 8'hFF;
    chk("keep_mask", s_out, 64'h00000000EEFF0011);
    s_pop = 1'b1; step(); s_pop = 1'b0;
    chk("keep_drain_empty", {63'd0, s_empty}, 64'd1);

    // Fill to full, then one pop lets a held fifth word in.
    s_tvalid = 1'b1;
    s_tdata = 64'hA1; step();
    s_tdata = 64'hA2; step();
    s_tdata = 64'hA3; step();
    s_tdata = 64'hA4; step();
    chk("full_flag", {63'd0, s_full}, 64'd1);
    chk("full_tready", {63'd0, s_tready}, 64'd0);
    chk("full_occ", {61'd0, s_occ}, 64'd4);
    s_tdata = 64'h5555; s_pop = 1'b1;
    step();
    s_pop = 1'b0;
    chk("full_pop_occ", {61'd0, s_occ}, 64'd3);
    chk("full_pop_tready", {63'd0, s_tready}, 64'd1);
    chk("full_pop_head", s_out, 64'hA2);
    step();
    s_tvalid = 1'b0;
    chk("refill_occ", {61'd0, s_occ}, 64'd4);
    chk("refill_full", {63'd0, s_full}, 64'd1);
    s_pop = 1'b1;
    chk("order0", s_out, 64'hA2); step();
    chk("order1", s_out, 64'hA3); step();
    chk("order2", s_out, 64'hA4); step();
    chk("order3", s_out, 64'h5555); step();
    chk("order_empty", {63'd0, s_empty}, 64'd1);

    // Underflow: pop while empty, with a push arriving in the second cycle.
    chk("ufl_c1_data", s_out, 64'd0);
    step();
    chk("ufl_c1_count", {48'd0, s_ufl}, 64'd1);
    s_tvalid = 1'b1; s_tdata = 64'h7777;
    chk("ufl_c2_data", s_out, 64'd0);
    step();
    s_tvalid = 1'b0;
    chk("ufl_c2_count", {48'd0, s_ufl}, 64'd2);
    chk("ufl_c2_occ", {61'd0, s_occ}, 64'd1);
    chk("ufl_c3_data", s_out, 64'h7777);
    step();
    s_pop = 1'b0;
    chk("ufl_end_count", {48'd0, s_ufl}, 64'd2);
    chk("ufl_end_empty", {63'd0, s_empty}, 64'd1);

    // DEPTH=512 stream: one underflow pop, then steady push+pop across wrap.
    b_pop = 1'b1; step(); b_pop = 1'b0;
    chk("big_ufl", {48'd0, b_ufl}, 64'd1);
    mism = 0;
    exp_rd = 64'd0;
    b_tvalid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      b_tdata = 64'(i) ^ 64'hC0DE_0000_0000_0000;
      b_pop = (i > 0);
      if (i > 0) begin
        if (b_out !== (exp_rd ^ 64'hC0DE_0000_0000_0000)) mism++;
        exp_rd++;
      end
      step();
    end
    chk("big_stream_mismatches", 64'(mism), 64'd0);
    chk("big_stream_occ", {54'd0, b_occ}, 64'd1);
    chk("big_stream_head", b_out, 64'd1999 ^ 64'hC0DE_0000_0000_0000);
    chk("big_stream_ufl", {48'd0, b_ufl}, 64'd1);

    // Asynchronous reset mid-stream, sampled before the next edge.
    #2;
    b_rst_n = 1'b0;
    #1;
    chk("big_rst_occ", {54'd0, b_occ}, 64'd0);
    chk("big_rst_ufl", {48'd0, b_ufl}, 64'd0);
    chk("big_rst_data", b_out, 64'd0);
    chk("big_rst_tready", {63'd0, b_tready}, 64'd0);
    b_tvalid = 1'b0; b_pop = 1'b0;
    step();
    b_rst_n = 1'b1;
    step();
    chk("big_post_empty", {63'd0, b_empty}, 64'd1);
    chk("big_post_tready", {63'd0, b_tready}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case the directed sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
